// File: rtl/sram_access_ctrl_pkg.sv
// rtl/sram_access_ctrl_pkg.sv - shared types and defaults for the SRAM access controller
//   Contents: FSM state enum, SRAM data width, default address width and base
//   address, and the CPU-byte-address to SRAM-word-index helper.
package sram_access_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOW  = 2'd1,
        S_HIGH = 2'd2,
        S_DONE = 2'd3
    } state_e;

    localparam int SRAM_DW           = 16;
    localparam int DEFAULT_SRAM_AW   = 18;
    localparam int DEFAULT_BASE_ADDR = 1024;

    // Word index relative to the SRAM window; callers truncate to their width.
    function automatic logic [31:0] word_index(input logic [31:0] addr,
                                               input logic [31:0] base);
        return (addr - base) >> 2;
    endfunction

endpackage

// File: rtl/sram_access_ctrl_if.sv
// rtl/sram_access_ctrl_if.sv - pipeline request and SRAM bus bundle for sram_access_ctrl
//   Pipeline side: MEM_R_EN, MEM_W_EN, address, write_data in; read_data, ready out.
//   SRAM side: sram_addr, sram_dq_out, sram_dq_oe, sram_we_n out; sram_dq_in in.
//   slave modport = the controller, master modport = pipeline plus SRAM device.
interface sram_access_ctrl_if
    import sram_access_ctrl_pkg::*;
#(
    parameter int SRAM_AW = DEFAULT_SRAM_AW
) ();

    logic               MEM_R_EN;
    logic               MEM_W_EN;
    logic [31:0]        address;
    logic [31:0]        write_data;
    logic [31:0]        read_data;
    logic               ready;
    logic [SRAM_AW-1:0] sram_addr;
    logic [SRAM_DW-1:0] sram_dq_out;
    logic               sram_dq_oe;
    logic [SRAM_DW-1:0] sram_dq_in;
    logic               sram_we_n;

    modport slave (
        input  MEM_R_EN, MEM_W_EN, address, write_data, sram_dq_in,
        output read_data, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
    );

    modport master (
        output MEM_R_EN, MEM_W_EN, address, write_data, sram_dq_in,
        input  read_data, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
    );

endinterface

// File: rtl/sram_access_ctrl.sv
// rtl/sram_access_ctrl.sv - 32-bit MEM-stage access sequenced as two 16-bit SRAM phases
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : sram_access_ctrl_if.slave (pipeline request/ready, SRAM bus)
//   WAIT_CYCLES (2..15) cycles per halfword phase; BASE_ADDR maps to SRAM word 0.
module sram_access_ctrl
    import sram_access_ctrl_pkg::*;
#(
    parameter int WAIT_CYCLES = 3,
    parameter int BASE_ADDR   = DEFAULT_BASE_ADDR,
    parameter int SRAM_AW     = DEFAULT_SRAM_AW
) (
    input  logic                  clk,
    input  logic                  rst,
    sram_access_ctrl_if.slave     bus
);

    localparam logic [1:0] IDLE = 2'(S_IDLE);
    localparam logic [1:0] LOW  = 2'(S_LOW);
    localparam logic [1:0] HIGH = 2'(S_HIGH);
    localparam logic [1:0] DONE = 2'(S_DONE);

    localparam int         WORD_W = SRAM_AW - 1;
    localparam logic [3:0] LAST   = 4'(WAIT_CYCLES - 1);

    logic [1:0]         state;
    logic [3:0]         cnt;
    logic               op_write;
    logic [WORD_W-1:0]  word;
    logic [31:0]        wdata;
    logic [SRAM_DW-1:0] lo_half;
    logic [31:0]        read_data_q;
    logic               req;
    logic               last_cycle;

    assign req        = bus.MEM_R_EN | bus.MEM_W_EN;
    assign last_cycle = (cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            op_write    <= 1'b0;
            word        <= '0;
            wdata       <= '0;
            lo_half     <= '0;
            read_data_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        // Write wins when both enables are high.
                        op_write <= bus.MEM_W_EN;
                        word     <= WORD_W'(word_index(bus.address, 32'(BASE_ADDR)));
                        wdata    <= bus.write_data;
                        cnt      <= '0;
                        state    <= LOW;
                    end
                end
                LOW: begin
                    if (last_cycle) begin
                        if (!op_write) begin
                            lo_half <= bus.sram_dq_in;
                        end
                        cnt   <= '0;
                        state <= HIGH;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                HIGH: begin
                    if (last_cycle) begin
                        if (!op_write) begin
                            read_data_q <= {bus.sram_dq_in, lo_half};
                        end
                        cnt   <= '0;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                default: begin
                    // DONE: the pipeline advances on this edge, so never linger.
                    state <= IDLE;
                end
            endcase
        end
    end

    // SRAM strobes are decoded from registered state only; the last cycle of
    // each write phase keeps data driven with we_n high as a hold cycle.
    always_comb begin
        bus.sram_addr   = '0;
        bus.sram_dq_out = '0;
        bus.sram_dq_oe  = 1'b0;
        bus.sram_we_n   = 1'b1;
        case (state)
            LOW: begin
                bus.sram_addr = {word, 1'b0};
                if (op_write) begin
                    bus.sram_dq_out = wdata[15:0];
                    bus.sram_dq_oe  = 1'b1;
                    bus.sram_we_n   = last_cycle;
                end
            end
            HIGH: begin
                bus.sram_addr = {word, 1'b1};
                if (op_write) begin
                    bus.sram_dq_out = wdata[31:16];
                    bus.sram_dq_oe  = 1'b1;
                    bus.sram_we_n   = last_cycle;
                end
            end
            default: begin
            end
        endcase
    end

    // ready drops in the request cycle itself so the pipeline freezes at once;
    // reset forces it high so an aborted access releases the pipeline.
    always_comb begin
        case (state)
            IDLE:    bus.ready = rst | ~req;
            DONE:    bus.ready = 1'b1;
            default: bus.ready = rst;
        endcase
    end

    assign bus.read_data = read_data_q;

endmodule
